// File: rtl/eep_spi_responder_if.sv
// SPI link between the command-config block (master) and the calibration
// EEPROM responder (slave), plus the responder's status outputs.
interface eep_spi_responder_if;
  logic       SS_n;
  logic       SCLK;
  logic       MOSI;
  logic       MISO;
  logic       wr_done;
  logic       rd_done;
  logic       frame_err;
  logic [7:0] rd_data;

  modport master (
    output SS_n, SCLK, MOSI,
    input  MISO, wr_done, rd_done, frame_err, rd_data
  );

  modport slave (
    input  SS_n, SCLK, MOSI,
    output MISO, wr_done, rd_done, frame_err, rd_data
  );
endinterface

// File: rtl/eep_spi_responder.sv
// SPI mode-0 responder modelling the calibration EEPROM on ss[2].
// 16-bit frames: {op[1:0], addr[5:0], data[7:0]}; op 01 writes, op 00 reads
// with the stored byte returned on MISO during the low byte of the frame.
// SCLK, SS_n and MOSI are oversampled on clk; all state is clk-synchronous.
module eep_spi_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                rst,
  eep_spi_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   ss_prev;

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  state_t        state;
  logic [4:0]    cnt;
  // Only the byte currently being received is ever consumed (command byte at
  // the 8th rise, data byte at commit), so an 8-bit window of the 16-bit
  // frame shift register carries all the information needed.
  logic [7:0]    sr;
  logic [7:0]    sr_next;
  logic [1:0]    op;
  logic [AW-1:0] addr;
  logic [7:0]    tx_byte;
  logic          bad;
  logic          miso_q;
  logic          wr_done_q;
  logic          rd_done_q;
  logic          frame_err_q;
  logic [7:0]    rd_data_q;
  logic [7:0]    mem [DEPTH];

  // Metastability chains and previous-sample registers for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      ss_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.SS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
      sclk_prev <= sclk_s;
      ss_prev   <= ss_s;
    end
  end

  // Edge strobes derived from the synchronised copies.
  always_comb begin
    sclk_s    = sclk_sync[SYNC_STAGES-1];
    ss_s      = ss_sync[SYNC_STAGES-1];
    mosi_s    = mosi_sync[SYNC_STAGES-1];
    sclk_rise = sclk_s & ~sclk_prev;
    sclk_fall = ~sclk_s & sclk_prev;
    ss_rise   = ss_s & ~ss_prev;
    ss_fall   = ~ss_s & ss_prev;
    sr_next   = {sr[6:0], mosi_s};
  end

  // Frame FSM, array and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sr          <= '0;
      op          <= '0;
      addr        <= '0;
      tx_byte     <= '0;
      bad         <= 1'b0;
      miso_q      <= 1'b0;
      wr_done_q   <= 1'b0;
      rd_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rd_data_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_done_q   <= 1'b0;
      rd_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      case (state)
        IDLE: begin
          miso_q <= 1'b0;
          bad    <= 1'b0;
          if (ss_fall) begin
            cnt   <= '0;
            state <= CMD;
          end
        end
        CMD: begin
          if (ss_rise) begin
            frame_err_q <= 1'b1;
            state       <= IDLE;
          end else if (sclk_rise) begin
            cnt <= cnt + 5'd1;
            sr  <= sr_next;
            if (cnt == 5'd7) begin
              op   <= sr_next[7:6];
              addr <= sr_next[AW-1:0];
              if (sr_next[7:6] == 2'b00) begin
                tx_byte   <= mem[sr_next[AW-1:0]];
                rd_data_q <= mem[sr_next[AW-1:0]];
              end
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (ss_rise) begin
            frame_err_q <= 1'b1;
            miso_q      <= 1'b0;
            state       <= IDLE;
          end else begin
            if (sclk_rise) begin
              cnt <= cnt + 5'd1;
              sr  <= sr_next;
              if (cnt == 5'd15) begin
                miso_q <= 1'b0;
                state  <= DONE;
              end
            end
            // Shifting on every fall (first one included) presents bit 7
            // after the 8th rise and bit 0 before the 16th.
            if (sclk_fall && op == 2'b00) begin
              miso_q  <= tx_byte[7];
              tx_byte <= {tx_byte[6:0], 1'b0};
            end
          end
        end
        DONE: begin
          if (ss_rise) begin
            miso_q <= 1'b0;
            state  <= IDLE;
            if (!bad) begin
              if (op == 2'b01) begin
                mem[addr] <= sr;
                wr_done_q <= 1'b1;
              end else if (op == 2'b00) begin
                rd_done_q <= 1'b1;
              end
            end
          end else if (sclk_rise && !bad) begin
            frame_err_q <= 1'b1;
            bad         <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // MISO is forced low by the raw chip select so it never leaks while the
  // synchroniser is still catching up with a deselect.
  assign bus.MISO      = miso_q & ~bus.SS_n;
  assign bus.wr_done   = wr_done_q;
  assign bus.rd_done   = rd_done_q;
  assign bus.frame_err = frame_err_q;
  assign bus.rd_data   = rd_data_q;

endmodule

// File: tb/tb_eep_spi_responder.sv
// Directed bench for the calibration EEPROM SPI responder.
module tb_eep_spi_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   wr_cnt = 0;
  int   rd_cnt = 0;
  int   err_cnt = 0;

  eep_spi_responder_if bus ();

  eep_spi_responder #(.DEPTH(64), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Pulse counters: a pulse held longer than one clk counts more than once.
  always @(posedge clk) begin
    if (bus.wr_done === 1'b1)   wr_cnt  <= wr_cnt + 1;
    if (bus.rd_done === 1'b1)   rd_cnt  <= rd_cnt + 1;
    if (bus.frame_err === 1'b1) err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame();
    @(negedge clk);
    bus.SS_n = 1'b0;
    wait_clk(4);
  endtask

  task automatic clock_bit(input logic b, output logic m);
    bus.MOSI = b;
    wait_clk(4);
    m = bus.MISO;
    bus.SCLK = 1'b1;
    wait_clk(4);
    bus.SCLK = 1'b0;
  endtask

  task automatic end_frame();
    wait_clk(4);
    bus.SS_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic send_bits(input logic [15:0] w, input int n, output logic [7:0] rx);
    logic m;
    rx = '0;
    for (int i = 0; i < n; i++) begin
      clock_bit(w[15-i], m);
      if (i >= 8) rx[15-i] = m;
    end
  endtask

  task automatic frame(input logic [15:0] w, output logic [7:0] rx);
    start_frame();
    send_bits(w, 16, rx);
    end_frame();
  endtask

  initial begin
    logic [7:0] rx;
    logic       m;
    int w0, r0, e0;

    bus.SS_n = 1'b1;
    bus.SCLK = 1'b0;
    bus.MOSI = 1'b0;
    wait_clk(5);
    check("rst_miso", {15'd0, bus.MISO}, 16'd0);
    check("rst_wr_done", {15'd0, bus.wr_done}, 16'd0);
    check("rst_rd_done", {15'd0, bus.rd_done}, 16'd0);
    check("rst_frame_err", {15'd0, bus.frame_err}, 16'd0);
    check("rst_rd_data", {8'd0, bus.rd_data}, 16'd0);
    rst = 1'b0;
    wait_clk(5);

    // Write 0x0A <= 0x5C, then read it back.
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
    frame(16'h4A5C, rx);
    check("wr0a_wr_done", 16'(wr_cnt - w0), 16'd1);
    check("wr0a_rd_done", 16'(rd_cnt - r0), 16'd0);
    check("wr0a_err", 16'(err_cnt - e0), 16'd0);
    check("idle_miso", {15'd0, bus.MISO}, 16'd0);
    w0 = wr_cnt; r0 = rd_cnt;
    frame(16'h0A00, rx);
    check("rd0a_miso", {8'd0, rx}, 16'h005C);
    check("rd0a_rd_data", {8'd0, bus.rd_data}, 16'h005C);
    check("rd0a_rd_done", 16'(rd_cnt - r0), 16'd1);
    check("rd0a_wr_done", 16'(wr_cnt - w0), 16'd0);

    // Read of an untouched location.
    r0 = rd_cnt; e0 = err_cnt;
    frame(16'h3F00, rx);
    check("rd3f_miso", {8'd0, rx}, 16'h0000);
    check("rd3f_rd_data", {8'd0, bus.rd_data}, 16'h0000);
    check("rd3f_rd_done", 16'(rd_cnt - r0), 16'd1);
    check("rd3f_err", 16'(err_cnt - e0), 16'd0);

    // Write aborted after 12 bits.
    w0 = wr_cnt; e0 = err_cnt;
    start_frame();
    send_bits(16'h4177, 12, rx);
    end_frame();
    check("abort_err", 16'(err_cnt - e0), 16'd1);
    check("abort_wr_done", 16'(wr_cnt - w0), 16'd0);
    frame(16'h0100, rx);
    check("abort_rd01", {8'd0, rx}, 16'h0000);

    // Write followed by a 17th SCLK pulse.
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
    start_frame();
    send_bits(16'h4211, 16, rx);
    clock_bit(1'b1, m);
    end_frame();
    check("bit17_err", 16'(err_cnt - e0), 16'd1);
    check("bit17_wr_done", 16'(wr_cnt - w0), 16'd0);
    check("bit17_rd_done", 16'(rd_cnt - r0), 16'd0);
    frame(16'h0200, rx);
    check("bit17_rd02", {8'd0, rx}, 16'h0000);

    // Op 11 does nothing; then write/read the top address.
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
    frame(16'hC3FF, rx);
    check("op11_pulses", 16'((wr_cnt - w0) + (rd_cnt - r0) + (err_cnt - e0)), 16'd0);
    frame(16'h0300, rx);
    check("op11_rd03", {8'd0, rx}, 16'h0000);
    w0 = wr_cnt;
    frame(16'h7FA5, rx);
    check("wr3f_wr_done", 16'(wr_cnt - w0), 16'd1);
    frame(16'h3F00, rx);
    check("rd3f_new_miso", {8'd0, rx}, 16'h00A5);
    check("rd3f_new_rd_data", {8'd0, bus.rd_data}, 16'h00A5);

    // Reset mid-write after 10 bits.
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
    start_frame();
    send_bits(16'h4533, 10, rx);
    @(negedge clk);
    rst = 1'b1;
    wait_clk(2);
    check("midrst_miso", {15'd0, bus.MISO}, 16'd0);
    check("midrst_rd_data", {8'd0, bus.rd_data}, 16'h0000);
    bus.SS_n = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(8);
    check("midrst_pulses", 16'((wr_cnt - w0) + (rd_cnt - r0) + (err_cnt - e0)), 16'd0);
    frame(16'h0500, rx);
    check("midrst_rd05", {8'd0, rx}, 16'h0000);
    frame(16'h3F00, rx);
    check("midrst_rd3f_cleared", {8'd0, rx}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eep_spi_responder.md
Name: eep_spi_responder

Overview:
- SPI slave model of the calibration EEPROM: the responder end of the 16-bit SPI frames the command-config block issues on the EEPROM chip select (ss[2]).
- Decodes write frames {2'b01, addr[5:0], data[7:0]} and read frames {2'b00, addr[5:0], 8'hxx}.
- Holds a 64x8 calibration array and returns read data on MISO in the low byte of the same frame.
- Used in system simulation and on the FPGA stand-in board; fully synchronous to clk, with SCLK and SS_n oversampled.

Parameters:
- DEPTH, 64, number of 8-bit locations; address width is log2(DEPTH) = 6.
- SYNC_STAGES, 2, flops in the metastability chain on SCLK, SS_n and MOSI (minimum 2).

Ports:
- clk  input  1  system clock, at least 8x SCLK.
- rst  input  1  asynchronous reset, active-high.
- SS_n  input  1  chip select from master, active-low.
- SCLK  input  1  SPI clock, mode 0 (idle low).
- MOSI  input  1  master out, MSB first.
- MISO  output  1  slave out.
- wr_done  output  1  one-clk pulse when a write commits.
- rd_done  output  1  one-clk pulse when a read frame completes.
- frame_err  output  1  one-clk pulse on an aborted or malformed frame.
- rd_data  output  8  byte most recently returned on MISO.

Behaviour:
- Reset: all outputs 0; rd_data = 8'h00; every array location = 8'h00; state IDLE; bit counter 0.
- Synchronisation: SCLK, SS_n and MOSI each pass through SYNC_STAGES flops.
  - rise = sync_sclk & ~prev; fall = ~sync_sclk & prev.
  - MOSI is sampled from its synchronised copy on a detected rise.
- Bit counter (5 bits) increments on each rise while SS_n is low; the 16-bit shift register shifts left with MOSI into the LSB.
- States:
  - IDLE: MISO = 0. A synchronised SS_n falling edge clears the counter and goes to CMD.
  - CMD: bits 15..8. After the 8th rise, latch op = sr[7:6] and addr = sr[5:0], then go to DATA.
    - If op == 00: load tx_byte = mem[addr] and rd_data = mem[addr] in the same clk.
  - DATA: bits 7..0.
    - op == 00: MISO = tx_byte[7] becomes valid on the fall after the 8th rise (before the master's 9th rise). tx_byte shifts left on each subsequent fall. MISO = 0 for any other op.
    - After the 16th rise, go to DONE.
  - DONE: wait for SS_n rising edge, then commit and return to IDLE.
    - op == 01: mem[addr] <= sr[7:0]; pulse wr_done.
    - op == 00: pulse rd_done.
    - op == 10 or 11: no array change, no done pulse, no error.
- Commit latency: the write is visible, and the pulse asserts, on the clk after the synchronised SS_n rise is detected.
- Boundary conditions:
  - SS_n rises in CMD or DATA (fewer than 16 bits): abort, no write, pulse frame_err, return to IDLE.
  - A rise while in DONE (17th bit): pulse frame_err once and mark the frame bad. SS_n rise then returns to IDLE with no write and no done pulse.
  - SCLK edges while SS_n is high are ignored. MISO stays 0 whenever SS_n is high.
  - SS_n falls again in the same clk as a commit: the commit completes and the new frame starts in CMD with counter 0.
  - rst asserted mid-frame: immediate return to IDLE, array cleared, no pulses.
  - Read of a location written in the previous frame returns the new value.
  - Back-to-back frames need at least 2 clk of SS_n high.

Test Plan:
- Write frame 16'h4A5C (addr 0x0A, data 8'h5C), then read frame 16'h0A00 -> wr_done pulses once, then rd_done; MISO bits in the low byte = 0,1,0,1,1,1,0,0; rd_data = 8'h5C.
- Read addr 0x3F after reset (frame 16'h3F00) -> MISO low byte all 0, rd_data = 8'h00, rd_done pulses, no frame_err.
- Write 16'h4177, SS_n raised after 12 bits -> frame_err pulses, no wr_done; a following read of addr 0x01 returns 8'h00.
- Write 16'h4211 followed by a 17th SCLK pulse -> exactly one frame_err; mem[2] stays 8'h00.
- Op 11 frame 16'hC3FF -> no pulses; array unchanged. Then write 16'h7FA5 and read 16'h3F00 -> 8'hA5.
- Assert rst mid-write of 16'h4533 after 10 bits -> MISO = 0, no pulses; mem[5] reads 8'h00 after reset release.
